y_capture_checker: RTL and testbench
====================================

Name: y_capture_checker

Overview:
- Receive-side companion to the generated combinational DUTs, which drive a packed 117-bit y vector through #5-delayed assigns.
- After each stimulus change, waits for the DUT's y to settle, samples it alongside the golden-model y, and compares the two.
- Reports pass/fail, the lowest mismatching bit, a settle timeout, and running statistics.
- Sits in the differential-test harness between the DUT/golden pair and the result logger.

Parameters:
WIDTH, 117, width of the compared y vectors
STABLE_CYCLES, 8, consecutive unchanged cycles of dut_y required before sampling (>=1)
TIMEOUT, 64, maximum settle cycles before declaring timeout (must be > STABLE_CYCLES)
CNT_W, 16, width of statistics counters
IDX_W, 7, width of mismatch_idx; 2^IDX_W > WIDTH

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  pulse: new stimulus applied to DUT and golden model
clr_stats  in  1  clear statistics counters and sticky_fail
dut_y  in  WIDTH  y from the DUT
ref_y  in  WIDTH  y from the golden model
busy  out  1  check in progress (state != IDLE)
done  out  1  one-cycle pulse, result valid
pass  out  1  last result: match and no timeout
timeout  out  1  last result: dut_y never stabilised
mismatch_idx  out  IDX_W  lowest differing bit of last check; all-ones if none or timeout
vec_cnt  out  CNT_W  checks completed (saturating)
fail_cnt  out  CNT_W  failed checks, including timeouts (saturating)
sticky_fail  out  1  set on any failure; held until reset or clr_stats

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; busy=0, done=0, pass=0, timeout=0, mismatch_idx=all-ones, vec_cnt=0, fail_cnt=0, sticky_fail=0; internal registers (dut_q, ref_q, diff, stab, tmo) cleared. Reset mid-check aborts without report.
- FSM states: IDLE, SETTLE, COMPARE, REPORT.
- IDLE:
  - On start=1: dut_q<=dut_y, ref_q<=ref_y, stab<=0, tmo<=0, go to SETTLE.
  - start while busy is ignored; it is neither queued nor counted.
- SETTLE, each cycle:
  - tmo<=tmo+1; ref_q<=ref_y.
  - If dut_y==dut_q, stab<=stab+1; else stab<=0 and dut_q<=dut_y.
  - When the incremented stab equals STABLE_CYCLES, go to COMPARE (stability takes priority over timeout in the same cycle).
  - Otherwise, when the incremented tmo equals TIMEOUT, go to REPORT with the timeout flag set.
- COMPARE: diff<=dut_q^ref_q; go to REPORT.
- REPORT, one cycle:
  - done=1; pass=(diff==0)&&!timeout_flag; timeout=timeout_flag.
  - mismatch_idx=index of lowest set bit of diff; all-ones if diff==0 or on timeout.
  - vec_cnt+1; on fail, fail_cnt+1 and sticky_fail=1.
  - Return to IDLE.
  - pass, timeout and mismatch_idx hold until the next REPORT.
- Latency: with dut_y stable, start sampled at edge 0 gives done high in cycle STABLE_CYCLES+2 (cycle 10 at default). A new start is accepted the cycle after done.
- Counters saturate at 2^CNT_W-1; no wrap.
- clr_stats clears vec_cnt, fail_cnt and sticky_fail in any state. When coincident with REPORT, clear wins: that result updates pass/timeout/mismatch_idx but is not counted.
- Comparison is bitwise over all WIDTH bits, including bit 0, which the DUT ties to 0. X/Z on inputs is out of scope.

Test Plan:
- Equal stable vectors: dut_y=ref_y=117'h1 held, start pulse → done in cycle 10, pass=1, mismatch_idx=7'h7F, vec_cnt=1, fail_cnt=0.
- Single-bit mismatch: ref_y=0, dut_y with bits 40 and 90 set → pass=0, mismatch_idx=40, fail_cnt=1, sticky_fail=1.
- Settle restart: dut_y changes at cycles 3 and 6 after start, then holds → done in cycle 6+8+2=16, compared against the final value.
- Timeout: dut_y toggles every cycle → done in cycle 65, timeout=1, pass=0, mismatch_idx=7'h7F, fail_cnt incremented.
- Busy/start and clr_stats: second start pulsed during SETTLE is ignored, vec_cnt=1 after one done. clr_stats asserted in the REPORT cycle leaves vec_cnt=0 and sticky_fail=0 while pass still reflects that result.
- Reset mid-SETTLE and saturation: rst_n=0 for one cycle while busy → busy=0, no done, all outputs at reset values. Preload 65535 checks → vec_cnt stays 16'hFFFF on the next check.

Source files
------------

// File: rtl/y_capture_checker_if.sv
// y_capture_checker_if: stimulus/result bundle between the harness (master) and the y capture checker (slave).
//   master drives: start, clr_stats, dut_y, ref_y
//   slave drives : busy, done, pass, timeout, mismatch_idx, vec_cnt, fail_cnt, sticky_fail
interface y_capture_checker_if #(
    parameter int WIDTH = 117,
    parameter int IDX_W = 7,
    parameter int CNT_W = 16
);
    logic             start;
    logic             clr_stats;
    logic [WIDTH-1:0] dut_y;
    logic [WIDTH-1:0] ref_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [IDX_W-1:0] mismatch_idx;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             sticky_fail;

    modport master (
        output start, clr_stats, dut_y, ref_y,
        input  busy, done, pass, timeout, mismatch_idx, vec_cnt, fail_cnt, sticky_fail
    );

    modport slave (
        input  start, clr_stats, dut_y, ref_y,
        output busy, done, pass, timeout, mismatch_idx, vec_cnt, fail_cnt, sticky_fail
    );
endinterface

// File: rtl/y_capture_checker.sv
// y_capture_checker: waits for dut_y to settle after each start, compares it with ref_y and keeps statistics.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : y_capture_checker_if slave (start/clr_stats/dut_y/ref_y in; busy/done/pass/timeout/
//           mismatch_idx/vec_cnt/fail_cnt/sticky_fail out)
module y_capture_checker #(
    parameter int WIDTH         = 117,
    parameter int STABLE_CYCLES = 8,
    parameter int TIMEOUT       = 64,
    parameter int CNT_W         = 16,
    parameter int IDX_W         = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    y_capture_checker_if.slave   bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, REPORT} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] dut_q, ref_q, diff_q;
    logic [SW-1:0]    stab_q, stab_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             tflag_q, done_q, pass_q, timeout_q, sticky_q;
    logic             same_d, fail_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] vec_q, fail_q;

    always_comb begin
        stab_d = stab_q + SW'(1);
        tmo_d  = tmo_q + TW'(1);
        same_d = bus.dut_y == dut_q;
        fail_d = tflag_q || (diff_q != '0);
        idx_d  = '1;
        // Descending scan so the lowest differing bit wins; a timed-out check reports all-ones.
        if (!tflag_q)
            for (int i = WIDTH - 1; i >= 0; i--)
                if (diff_q[i]) idx_d = IDX_W'(i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dut_q     <= '0;
            ref_q     <= '0;
            diff_q    <= '0;
            stab_q    <= '0;
            tmo_q     <= '0;
            tflag_q   <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            idx_q     <= '1;
            vec_q     <= '0;
            fail_q    <= '0;
            sticky_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    dut_q   <= bus.dut_y;
                    ref_q   <= bus.ref_y;
                    stab_q  <= '0;
                    tmo_q   <= '0;
                    tflag_q <= 1'b0;
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    tmo_q <= tmo_d;
                    ref_q <= bus.ref_y;
                    if (same_d) stab_q <= stab_d;
                    else begin
                        stab_q <= '0;
                        dut_q  <= bus.dut_y;
                    end
                    // Reaching stability on the final allowed cycle still counts as settled.
                    if (same_d && stab_d == SW'(STABLE_CYCLES)) state_q <= COMPARE;
                    else if (tmo_d == TW'(TIMEOUT)) begin
                        tflag_q <= 1'b1;
                        state_q <= REPORT;
                    end
                end
                COMPARE: begin
                    diff_q  <= dut_q ^ ref_q;
                    state_q <= REPORT;
                end
                REPORT: begin
                    done_q    <= 1'b1;
                    pass_q    <= !fail_d;
                    timeout_q <= tflag_q;
                    idx_q     <= idx_d;
                    vec_q     <= vec_q + CNT_W'(vec_q != '1);
                    if (fail_d) begin
                        fail_q   <= fail_q + CNT_W'(fail_q != '1);
                        sticky_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // Placed after the FSM so a clear coinciding with REPORT discards that result's counting.
            if (bus.clr_stats) begin
                vec_q    <= '0;
                fail_q   <= '0;
                sticky_q <= 1'b0;
            end
        end
    end

    assign bus.busy         = state_q != IDLE;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.timeout      = timeout_q;
    assign bus.mismatch_idx = idx_q;
    assign bus.vec_cnt      = vec_q;
    assign bus.fail_cnt     = fail_q;
    assign bus.sticky_fail  = sticky_q;
endmodule

// File: tb/tb_y_capture_checker.sv
// tb_y_capture_checker: directed and randomized checks of y_capture_checker against a sample-sequence model.
module tb_y_capture_checker;
    localparam int W = 117;
    localparam int S = 8;
    localparam int T = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    y_capture_checker_if bus ();
    y_capture_checker_if #(.CNT_W(4)) bus2 ();

    y_capture_checker dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    y_capture_checker #(.STABLE_CYCLES(1), .TIMEOUT(4), .CNT_W(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_chk = 0;
    int n_pass = 0;
    int mvec = 0;
    int mfail = 0;
    bit msticky = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] rnd();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    // Value of dut_y sampled at edge k after start (edge 0); the last entry holds forever.
    function automatic logic [W-1:0] samp(input logic [W-1:0] s[$], input int k);
        return (k < s.size()) ? s[k] : s[s.size() - 1];
    endfunction

    // First edge k (S <= k <= T) at which the last S+1 samples are identical, or -1.
    function automatic int settle_edge(input logic [W-1:0] s[$]);
        bit ok;
        for (int k = S; k <= T; k++) begin
            ok = 1'b1;
            for (int j = k - S; j < k; j++) if (samp(s, j) !== samp(s, k)) ok = 1'b0;
            if (ok) return k;
        end
        return -1;
    endfunction

    task automatic run(input string tag, input logic [W-1:0] r, input logic [W-1:0] s[$],
                       input bit clr_rep, input bit dup_start);
        int ke, d_exp, got, k, e;
        logic [W-1:0] diff;
        bit e_tmo, e_pass;
        logic [6:0] e_idx;
        ke    = settle_edge(s);
        e_tmo = ke < 0;
        d_exp = e_tmo ? T + 1 : ke + 2;
        diff  = e_tmo ? '0 : (samp(s, ke) ^ r);
        e_pass = !e_tmo && diff == '0;
        e_idx = 7'h7F;
        if (!e_tmo && diff != '0) begin
            e = 0;
            while (!diff[e]) e++;
            e_idx = 7'(e);
        end
        if (clr_rep) begin
            mvec = 0; mfail = 0; msticky = 1'b0;
        end else begin
            mvec = (mvec == 65535) ? mvec : mvec + 1;
            if (!e_pass) begin
                mfail = (mfail == 65535) ? mfail : mfail + 1;
                msticky = 1'b1;
            end
        end
        bus.ref_y = r;
        bus.dut_y = s[0];
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 0;
        got = -1;
        while (k < 200 && got < 0) begin
            if (k == 1) chk({tag, "_busy"}, bus.busy, 1'b1);
            bus.dut_y = samp(s, k + 1);
            bus.start = dup_start && k == 2;
            bus.clr_stats = clr_rep && k == d_exp - 1;
            @(posedge clk); #1;
            k++;
            bus.start = 1'b0;
            bus.clr_stats = 1'b0;
            if (bus.done) got = k;
        end
        chk({tag, "_done_cycle"}, got, d_exp);
        chk({tag, "_pass"}, bus.pass, e_pass);
        chk({tag, "_timeout"}, bus.timeout, e_tmo);
        chk({tag, "_idx"}, bus.mismatch_idx, e_idx);
        chk({tag, "_vec_cnt"}, bus.vec_cnt, mvec);
        chk({tag, "_fail_cnt"}, bus.fail_cnt, mfail);
        chk({tag, "_sticky"}, bus.sticky_fail, msticky);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, bus.done, 1'b0);
        chk({tag, "_idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        logic [W-1:0] q[$];
        logic [W-1:0] a, b, c, v, r;
        int seen, w;
        bus.start = 1'b0; bus.clr_stats = 1'b0; bus.dut_y = '0; bus.ref_y = '0;
        bus2.start = 1'b0; bus2.clr_stats = 1'b0; bus2.dut_y = '0; bus2.ref_y = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_pass", bus.pass, 1'b0);
        chk("rst_timeout", bus.timeout, 1'b0);
        chk("rst_idx", bus.mismatch_idx, 7'h7F);
        chk("rst_vec", bus.vec_cnt, 16'h0);
        chk("rst_fail", bus.fail_cnt, 16'h0);
        chk("rst_sticky", bus.sticky_fail, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        q = {W'(1)};
        run("equal", W'(1), q, 1'b0, 1'b0);

        a = (W'(1) << 40) | (W'(1) << 90);
        q = {a};
        run("mismatch", '0, q, 1'b0, 1'b0);

        a = rnd(); b = rnd(); c = rnd();
        q = {a, a, a, b, b, b, c};
        run("restart", c, q, 1'b0, 1'b0);

        a = rnd();
        q.delete();
        for (int i = 0; i < 70; i++) q.push_back((i % 2) ? ~a : a);
        run("timeout", a, q, 1'b0, 1'b0);

        a = rnd();
        q = {a};
        run("dup_clr_bit0", a ^ W'(1), q, 1'b1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            q.delete();
            v = rnd();
            repeat ($urandom_range(0, 3)) begin
                repeat ($urandom_range(1, 10)) q.push_back(v);
                v = rnd();
            end
            q.push_back(v);
            case ($urandom_range(0, 2))
                0: r = v;
                1: r = v ^ (W'(1) << $urandom_range(0, W - 1));
                default: r = rnd();
            endcase
            run($sformatf("rnd%0d", i), r, q, 1'b0, 1'b0);
        end

        a = rnd();
        bus.dut_y = a; bus.ref_y = a; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_busy_before", bus.busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_pass", bus.pass, 1'b0);
        chk("midrst_timeout", bus.timeout, 1'b0);
        chk("midrst_idx", bus.mismatch_idx, 7'h7F);
        chk("midrst_vec", bus.vec_cnt, 16'h0);
        chk("midrst_fail", bus.fail_cnt, 16'h0);
        chk("midrst_sticky", bus.sticky_fail, 1'b0);
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1;
        end
        chk("midrst_no_done", seen, 0);
        mvec = 0; mfail = 0; msticky = 1'b0;

        a = rnd();
        q = {a};
        run("bit116", a ^ (W'(1) << 116), q, 1'b0, 1'b0);

        bus2.ref_y = '0;
        bus2.dut_y = W'(1) << 5;
        for (int i = 0; i < 16; i++) begin
            bus2.start = 1'b1;
            @(posedge clk); #1;
            bus2.start = 1'b0;
            w = 0;
            while (!bus2.done && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            chk($sformatf("sat_done%0d", i), bus2.done, 1'b1);
            if (i == 13) begin
                chk("sat_vec_14", bus2.vec_cnt, 4'hE);
                chk("sat_idx", bus2.mismatch_idx, 7'd5);
            end
            @(posedge clk); #1;
        end
        chk("sat_vec", bus2.vec_cnt, 4'hF);
        chk("sat_fail", bus2.fail_cnt, 4'hF);
        chk("sat_sticky", bus2.sticky_fail, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
